// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer_if
// Brief    : Control bundle between the sequencer and the processor datapath.
// Revision : 1.0
// ============================================================================
interface cpu_sequencer_if;
  logic       ce;
  logic [7:0] ir;
  logic       zero;
  logic       ram_ready;
  logic       muxa;
  logic       muxb;
  logic       muxc;
  logic       en_in;
  logic       en_pc;
  logic       en_da;
  logic       ram_we;
  logic [2:0] alu_sel;
  logic       halted;
  logic       fault;
  logic [15:0] retired;

  modport master (
    input  ce, ir, zero, ram_ready,
    output muxa, muxb, muxc, en_in, en_pc, en_da, ram_we, alu_sel,
           halted, fault, retired
  );

  modport slave (
    output ce, ir, zero, ram_ready,
    input  muxa, muxb, muxc, en_in, en_pc, en_da, ram_we, alu_sel,
           halted, fault, retired
  );
endinterface
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Brief    : Multi-cycle fetch/decode/execute sequencer with RAM-ready stall
//            and memory-timeout watchdog.
// Revision : 1.0
// ============================================================================
module cpu_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  wire logic           clk,
  input  wire logic           clr,
  cpu_sequencer_if.master     bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_HALT   = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_STA = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b0101;
  localparam logic [3:0] OP_JZ  = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [7:0] C_WDOG_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  wdog_q,  wdog_d;
  logic [15:0] retired_q, retired_d;

  logic [3:0] w_opcode;
  logic       w_mem_op;
  logic       w_waiting;
  logic       w_gate;
  logic       w_en_in, w_en_pc, w_en_da, w_ram_we;
  logic       w_unused_operand;

  assign w_opcode         = bus.ir[7:4];
  assign w_unused_operand = ^bus.ir[3:0];
  assign w_mem_op         = (w_opcode >= OP_LDA) && (w_opcode <= OP_SUB);
  assign w_waiting        = ((state_q == S_FETCH) || ((state_q == S_EXEC) && w_mem_op))
                            && !bus.ram_ready;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_FETCH;
      wdog_q    <= 8'd0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wdog_d    = wdog_q;
    retired_d = retired_q;
    if (bus.ce) begin
      case (state_q)
        S_FETCH:  if (bus.ram_ready) state_d = S_DECODE;
        S_DECODE: state_d = S_EXEC;
        S_EXEC: begin
          if (!w_mem_op || bus.ram_ready) begin
            retired_d = retired_q + 16'd1;
            state_d   = (w_opcode == OP_HLT) ? S_HALT : S_FETCH;
          end
        end
        default: ;
      endcase
      // A ready on the last permitted cycle completes the access instead of faulting.
      if (w_waiting && (wdog_q == C_WDOG_LAST))
        state_d = S_FAULT;
      if (state_d != state_q)
        wdog_d = 8'd0;
      else if (w_waiting)
        wdog_d = wdog_q + 8'd1;
    end
  end

  always_comb begin
    bus.muxa    = 1'b0;
    bus.muxb    = 1'b0;
    bus.muxc    = 1'b0;
    bus.alu_sel = 3'b000;
    w_en_in     = 1'b0;
    w_en_pc     = 1'b0;
    w_en_da     = 1'b0;
    w_ram_we    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.ram_ready) begin
          w_en_in = 1'b1;
          w_en_pc = 1'b1;
        end
      end
      S_EXEC: begin
        case (w_opcode)
          OP_LDA: begin
            bus.muxa = 1'b1;
            bus.muxb = 1'b1;
            w_en_da  = bus.ram_ready;
          end
          OP_STA: begin
            bus.muxa = 1'b1;
            w_ram_we = 1'b1;
          end
          OP_ADD: begin
            bus.muxa    = 1'b1;
            bus.alu_sel = 3'b001;
            w_en_da     = bus.ram_ready;
          end
          OP_SUB: begin
            bus.muxa    = 1'b1;
            bus.alu_sel = 3'b010;
            w_en_da     = bus.ram_ready;
          end
          OP_JMP: begin
            bus.muxc = 1'b1;
            w_en_pc  = 1'b1;
          end
          OP_JZ: begin
            bus.muxc = 1'b1;
            w_en_pc  = bus.zero;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Gating with clr keeps strobes low while reset is held, even in FETCH with ram_ready.
  assign w_gate      = bus.ce & clr;
  assign bus.en_in   = w_en_in  & w_gate;
  assign bus.en_pc   = w_en_pc  & w_gate;
  assign bus.en_da   = w_en_da  & w_gate;
  assign bus.ram_we  = w_ram_we & w_gate;
  assign bus.halted  = (state_q == S_HALT);
  assign bus.fault   = (state_q == S_FAULT);
  assign bus.retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Brief    : Directed self-checking bench for cpu_sequencer.
// Revision : 1.0
// ============================================================================
module tb_cpu_sequencer;

  logic clk;
  logic clr;
  int   n_chk;
  int   n_pass;

  cpu_sequencer_if u_if ();

  cpu_sequencer #(.TIMEOUT(15)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (u_if.master)
  );

  // {muxa, muxb, muxc, en_in, en_pc, en_da, ram_we, alu_sel[2:0], halted, fault}
  logic [11:0] w_outs;
  assign w_outs = {u_if.muxa, u_if.muxb, u_if.muxc, u_if.en_in, u_if.en_pc,
                   u_if.en_da, u_if.ram_we, u_if.alu_sel, u_if.halted, u_if.fault};

  localparam logic [11:0] O_IDLE  = 12'h000;
  localparam logic [11:0] O_FRDY  = 12'h180;
  localparam logic [11:0] O_LDAW  = 12'hC00;
  localparam logic [11:0] O_LDAR  = 12'hC40;
  localparam logic [11:0] O_STA   = 12'h820;
  localparam logic [11:0] O_ADD   = 12'h844;
  localparam logic [11:0] O_SUB   = 12'h848;
  localparam logic [11:0] O_JNT   = 12'h200;
  localparam logic [11:0] O_JMP   = 12'h280;
  localparam logic [11:0] O_HALT  = 12'h002;
  localparam logic [11:0] O_FAULT = 12'h001;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle's inputs at the falling edge, check, then advance to the next falling edge.
  task automatic cyc(input string tag, input logic [7:0] ir_v, input logic rdy_v,
                     input logic [11:0] exp_v);
    u_if.ir        = ir_v;
    u_if.ram_ready = rdy_v;
    #1;
    check(tag, {20'd0, w_outs}, {20'd0, exp_v});
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr            = 1'b0;
    u_if.ram_ready = 1'b1;
    u_if.ce        = 1'b1;
    #1;
    check("rst_outs", {20'd0, w_outs}, 32'd0);
    check("rst_retired", {16'd0, u_if.retired}, 32'd0);
    @(negedge clk);
    clr = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    clr = 1'b0;
    u_if.ce = 1'b1;
    u_if.ir = 8'h00;
    u_if.zero = 1'b0;
    u_if.ram_ready = 1'b0;
    @(negedge clk);

    // NOP stream
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc("nop_fetch",  8'h00, 1'b1, O_FRDY);
      cyc("nop_decode", 8'h00, 1'b1, O_IDLE);
      cyc("nop_exec",   8'h00, 1'b1, O_IDLE);
    end
    check("nop_retired", {16'd0, u_if.retired}, 32'd4);

    // LDA with two stall cycles
    do_reset();
    cyc("lda_fetch",  8'h15, 1'b1, O_FRDY);
    cyc("lda_decode", 8'h15, 1'b1, O_IDLE);
    cyc("lda_wait1",  8'h15, 1'b0, O_LDAW);
    cyc("lda_wait2",  8'h15, 1'b0, O_LDAW);
    cyc("lda_done",   8'h15, 1'b1, O_LDAR);
    check("lda_retired", {16'd0, u_if.retired}, 32'd1);
    // ce=0 freezes FETCH and an EXEC access mid-instruction
    u_if.ce = 1'b0;
    cyc("ce0_fetch",  8'h15, 1'b1, O_IDLE);
    u_if.ce = 1'b1;
    cyc("ce1_fetch",  8'h15, 1'b1, O_FRDY);
    cyc("ce_decode",  8'h15, 1'b1, O_IDLE);
    u_if.ce = 1'b0;
    cyc("ce0_exec",   8'h15, 1'b1, O_LDAW);
    check("ce0_retired", {16'd0, u_if.retired}, 32'd1);
    u_if.ce = 1'b1;
    cyc("ce1_exec",   8'h15, 1'b1, O_LDAR);
    check("ce1_retired", {16'd0, u_if.retired}, 32'd2);

    // STA, ADD, SUB
    do_reset();
    cyc("sta_fetch",  8'h23, 1'b1, O_FRDY);
    cyc("sta_decode", 8'h23, 1'b1, O_IDLE);
    cyc("sta_exec",   8'h23, 1'b1, O_STA);
    cyc("add_fetch",  8'h37, 1'b1, O_FRDY);
    cyc("add_decode", 8'h37, 1'b1, O_IDLE);
    cyc("add_exec",   8'h37, 1'b1, O_ADD);
    cyc("sub_fetch",  8'h49, 1'b1, O_FRDY);
    cyc("sub_decode", 8'h49, 1'b1, O_IDLE);
    cyc("sub_exec",   8'h49, 1'b1, O_SUB);
    check("alu_retired", {16'd0, u_if.retired}, 32'd3);

    // Asynchronous reset drops ram_we mid-STA
    cyc("sta2_fetch",  8'h23, 1'b1, O_FRDY);
    cyc("sta2_decode", 8'h23, 1'b1, O_IDLE);
    u_if.ram_ready = 1'b0;
    #1;
    check("sta2_we", {20'd0, w_outs}, {20'd0, O_STA});
    clr = 1'b0;
    #1;
    check("async_rst_we", {20'd0, w_outs}, 32'd0);
    check("async_rst_ret", {16'd0, u_if.retired}, 32'd0);
    @(negedge clk);
    clr = 1'b1;

    // JZ not taken, JZ taken, JMP
    cyc("jz0_fetch",  8'h6A, 1'b1, O_FRDY);
    cyc("jz0_decode", 8'h6A, 1'b1, O_IDLE);
    cyc("jz0_exec",   8'h6A, 1'b1, O_JNT);
    u_if.zero = 1'b1;
    cyc("jz1_fetch",  8'h6A, 1'b1, O_FRDY);
    cyc("jz1_decode", 8'h6A, 1'b1, O_IDLE);
    cyc("jz1_exec",   8'h6A, 1'b1, O_JMP);
    u_if.zero = 1'b0;
    cyc("jmp_fetch",  8'h5C, 1'b1, O_FRDY);
    cyc("jmp_decode", 8'h5C, 1'b1, O_IDLE);
    cyc("jmp_exec",   8'h5C, 1'b1, O_JMP);
    check("jmp_retired", {16'd0, u_if.retired}, 32'd3);

    // Timeout in FETCH: fault on the 16th cycle
    do_reset();
    for (int i = 0; i < 15; i++) cyc("to_wait", 8'h00, 1'b0, O_IDLE);
    cyc("to_fault",  8'h00, 1'b1, O_FAULT);
    cyc("to_fault2", 8'h15, 1'b0, O_FAULT);
    cyc("to_fault3", 8'h15, 1'b1, O_FAULT);
    do_reset();
    // Ready on the 15th waiting cycle wins
    for (int i = 0; i < 14; i++) cyc("tw_wait", 8'h00, 1'b0, O_IDLE);
    cyc("tw_ready",  8'h00, 1'b1, O_FRDY);
    cyc("tw_decode", 8'h00, 1'b1, O_IDLE);
    cyc("tw_exec",   8'h00, 1'b1, O_IDLE);
    cyc("tw_fetch",  8'h00, 1'b1, O_FRDY);

    // HLT
    do_reset();
    cyc("hlt_fetch",  8'hF0, 1'b1, O_FRDY);
    cyc("hlt_decode", 8'hF0, 1'b1, O_IDLE);
    cyc("hlt_exec",   8'hF0, 1'b1, O_IDLE);
    check("hlt_retired", {16'd0, u_if.retired}, 32'd1);
    cyc("halt_1", 8'hF0, 1'b1, O_HALT);
    u_if.ce = 1'b0;
    cyc("halt_ce0", 8'h15, 1'b1, O_HALT);
    u_if.ce = 1'b1;
    cyc("halt_rdy0", 8'h15, 1'b0, O_HALT);
    cyc("halt_rdy1", 8'h23, 1'b1, O_HALT);
    check("halt_retired", {16'd0, u_if.retired}, 32'd1);
    do_reset();
    cyc("post_fetch", 8'h00, 1'b1, O_FRDY);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
